// File: rtl/cart_bus_ctrl.sv
// ----------------------------------------------------------------------------
// cart_bus_ctrl
//
// Cartridge bus controller. Accepts single CPU read/write requests through a
// valid/ready handshake and replays each one on an asynchronous-SRAM-style
// cartridge bus as a fixed SETUP / STROBE / HOLD sequence, reporting
// completion with a one-cycle rsp_valid pulse. After reset the cartridge
// reset line is stretched for RST_HOLD cycles before requests are accepted.
// A free-running cart_clk is derived from clk by a CLK_DIV half-period divider.
//
// Ports
//   clk, n_rst          system clock, asynchronous active-low reset
//   req_valid/ready     CPU request handshake (ready only while IDLE)
//   req_we/addr/wdata   request fields, captured at the handshake edge
//   rsp_valid           one-cycle pulse in the last HOLD cycle
//   rsp_rdata           read data, held until the next read capture
//   cart_clk            divided cartridge clock
//   cart_n_rst          cartridge reset (active low)
//   cart_n_rd/n_wr      read / write strobes (active low)
//   cart_n_cs           external-RAM chip select (active low, address window)
//   cart_addr           registered address bus
//   cart_data_o/oe      write data and its drive enable (tristate at top level)
//   cart_data_i         sampled bus data
// ----------------------------------------------------------------------------
module cart_bus_ctrl #(
    parameter int                 ADDR_W     = 16,
    parameter int                 DATA_W     = 8,
    parameter int                 SETUP_CYC  = 2,
    parameter int                 STROBE_CYC = 4,
    parameter int                 HOLD_CYC   = 1,
    parameter int                 CLK_DIV    = 4,
    parameter int                 RST_HOLD   = 8,
    parameter logic [ADDR_W-1:0]  CS_LO      = 16'hA000,
    parameter logic [ADDR_W-1:0]  CS_HI      = 16'hC000
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              cart_clk,
    output logic              cart_n_rst,
    output logic              cart_n_rd,
    output logic              cart_n_wr,
    output logic              cart_n_cs,
    output logic [ADDR_W-1:0] cart_addr,
    output logic [DATA_W-1:0] cart_data_o,
    output logic              cart_data_oe,
    input  logic [DATA_W-1:0] cart_data_i
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(SETUP_CYC, STROBE_CYC), max2(HOLD_CYC, RST_HOLD));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    // A divide-by-one divider still needs a one-bit counter to be legal.
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [DIV_W-1:0] D_LAST = DIV_W'(CLK_DIV - 1);

    generate
        if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 ||
            CLK_DIV < 1 || RST_HOLD < 1) begin : g_bad_cycles
            $error("cart_bus_ctrl: cycle-count parameters must all be >= 1");
        end
        if (CS_LO >= CS_HI) begin : g_bad_window
            $error("cart_bus_ctrl: CS_LO must be below CS_HI");
        end
    endgenerate

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  next_cnt;
    logic              we;
    logic              next_we;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] next_wdata;
    logic              handshake;
    logic              next_access;
    logic              next_in_win;
    logic              next_n_rd;
    logic              next_n_wr;
    logic              next_n_cs;
    logic              next_oe;
    logic              next_rsp;
    logic              capture;
    logic [DIV_W-1:0]  div_cnt;

    assign req_ready = (state == IDLE);
    assign handshake = req_valid && req_ready;

    // Phase counter counts 0..N-1 inside each phase and restarts at every
    // phase change, so it never exceeds MAX_CYC-1 and cannot wrap.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_we    = we;
        next_addr  = cart_addr;
        next_wdata = cart_data_o;
        case (state)
            BOOT: begin
                if (cnt == R_LAST) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            IDLE: begin
                if (handshake) begin
                    next_state = SETUP;
                    next_cnt   = '0;
                    next_we    = req_we;
                    next_addr  = req_addr;
                    next_wdata = req_wdata;
                end
            end
            SETUP: begin
                if (cnt == S_LAST) begin
                    next_state = STROBE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt == W_LAST) begin
                    next_state = HOLD;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == H_LAST) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = BOOT;
                next_cnt   = '0;
            end
        endcase
    end

    // Bus outputs are decoded from the next state and registered, so every
    // cart_* pin comes straight from a flop and lines up with the FSM phase.
    always_comb begin
        next_access = (next_state == SETUP) || (next_state == STROBE) || (next_state == HOLD);
        next_in_win = (next_addr >= CS_LO) && (next_addr < CS_HI);
        next_n_rd   = !(!next_we && ((next_state == SETUP) || (next_state == STROBE)));
        next_n_wr   = !(next_we && (next_state == STROBE));
        next_n_cs   = !(next_access && next_in_win);
        next_oe     = next_we && next_access;
        next_rsp    = (next_state == HOLD) && (next_cnt == H_LAST);
        capture     = (state == STROBE) && (cnt == W_LAST) && !we;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= BOOT;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            we           <= 1'b0;
            cart_addr    <= '0;
            cart_data_o  <= '0;
            cart_n_rst   <= 1'b0;
            cart_n_rd    <= 1'b1;
            cart_n_wr    <= 1'b1;
            cart_n_cs    <= 1'b1;
            cart_data_oe <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            we           <= next_we;
            cart_addr    <= next_addr;
            cart_data_o  <= next_wdata;
            cart_n_rst   <= (next_state != BOOT);
            cart_n_rd    <= next_n_rd;
            cart_n_wr    <= next_n_wr;
            cart_n_cs    <= next_n_cs;
            cart_data_oe <= next_oe;
            rsp_valid    <= next_rsp;
            if (capture) begin
                rsp_rdata <= cart_data_i;
            end
        end
    end

    // Free-running cartridge clock, unaffected by the access FSM.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_cnt  <= '0;
            cart_clk <= 1'b0;
        end else if (div_cnt == D_LAST) begin
            div_cnt  <= '0;
            cart_clk <= ~cart_clk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: doc/cart_bus_ctrl.md
CART_BUS_CTRL -- requirements
Module: cart_bus_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 16, address width; DATA_W, 8, data width; SETUP_CYC, 2, address-to-strobe cycles; STROBE_CYC, 4, strobe-active cycles; HOLD_CYC, 1, post-strobe hold cycles; CLK_DIV, 4, cart_clk half-period in clk cycles; RST_HOLD, 8, cart reset stretch cycles; CS_LO, 16'hA000, external-RAM window base (inclusive); CS_HI, 16'hC000, window top (exclusive).
REQ-002 SHALL have ports (name, direction, width, meaning): clk, in, 1, system clock; n_rst, in, 1, asynchronous active-low reset; req_valid, in, 1, CPU request; req_ready, out, 1, controller can accept; req_we, in, 1, 1 = write; req_addr, in, ADDR_W, address; req_wdata, in, DATA_W, write data; rsp_valid, out, 1, access-complete pulse; rsp_rdata, out, DATA_W, read data; cart_clk, out, 1, cartridge clock; cart_n_rst, out, 1, cartridge reset (active low); cart_n_rd, out, 1, read strobe (active low); cart_n_wr, out, 1, write strobe (active low); cart_n_cs, out, 1, RAM chip select (active low); cart_addr, out, ADDR_W, address bus; cart_data_o, out, DATA_W, drive data; cart_data_oe, out, 1, drive enable; cart_data_i, in, DATA_W, sampled bus data.
REQ-003 SHALL leave tristate buffering of the data bus to the top level; this block drives no inout.

Function
REQ-004 SHALL implement the FSM states BOOT, IDLE, SETUP, STROBE and HOLD.
REQ-005 BOOT: SHALL hold cart_n_rst=0 and count RST_HOLD cycles after reset release, then set cart_n_rst=1 and go to IDLE.
REQ-006 SHALL assert req_ready=1 only in IDLE; handshake = req_valid&&req_ready at a rising edge (cycle T).
REQ-007 On handshake SHALL register req_addr to cart_addr, req_wdata to cart_data_o and req_we internally; request inputs are don't-care after T.
REQ-008 SETUP SHALL occupy cycles T+1..T+S, STROBE T+S+1..T+S+W, and HOLD T+S+W+1..T+S+W+H (S, W, H = SETUP_CYC, STROBE_CYC, HOLD_CYC).
REQ-009 SHALL pulse rsp_valid=1 for exactly the last HOLD cycle; the FSM returns to IDLE and req_ready=1 at T+S+W+H+1, so back-to-back throughput is one access per S+W+H+1 cycles.
REQ-010 Read: SHALL assert cart_n_rd=0 during SETUP and STROBE and capture cart_data_i into rsp_rdata at the edge ending the last STROBE cycle; rsp_rdata then holds until the next read capture.
REQ-011 Write: SHALL assert cart_n_wr=0 during STROBE only, assert cart_data_oe=1 from SETUP through HOLD inclusive, and leave rsp_rdata unchanged.
REQ-012 cart_n_cs SHALL be 0 from SETUP through HOLD when CS_LO <= cart_addr < CS_HI (unsigned compare), and 1 otherwise and in IDLE/BOOT.
REQ-013 In IDLE: cart_n_rd=1, cart_n_wr=1, cart_data_oe=0, and cart_addr holds its last value.
REQ-014 All cart_* strobes and cart_addr SHALL be registered outputs with no combinational path from req_*.
REQ-015 cart_clk SHALL toggle every CLK_DIV clk cycles, free-running and independent of FSM state; its counter width SHALL be $clog2(CLK_DIV).
REQ-016 Phase counters SHALL be sized to $clog2(max(S,W,H,RST_HOLD)+1) and SHALL never wrap.
REQ-017 SETUP_CYC, STROBE_CYC, HOLD_CYC, CLK_DIV and RST_HOLD SHALL each be >=1, and CS_LO < CS_HI; violations SHALL be flagged by an elaboration-time check.
REQ-018 A request is never aborted: req_valid deasserting mid-access SHALL have no effect.

Reset
REQ-019 While n_rst=0, asynchronously: state=BOOT, req_ready=0, rsp_valid=0, rsp_rdata=0, cart_n_rst=0, cart_n_rd=1, cart_n_wr=1, cart_n_cs=1, cart_addr=0, cart_data_o=0, cart_data_oe=0, cart_clk=0, and all counters = 0.
REQ-020 Reset asserted mid-access SHALL abandon the access immediately with no rsp_valid; after release, the block re-enters BOOT and re-stretches cart_n_rst for RST_HOLD cycles.

Verification
REQ-021 Reset release at default parameters -> cart_n_rst=0 for 8 cycles, then cart_n_rst=1 and req_ready=1; cart_clk period = 8 clk cycles.
REQ-022 Read of 16'h0150 with the bus model returning 8'h3C -> cart_n_rd low for 6 cycles, cart_n_cs=1 throughout, rsp_valid at T+7, rsp_rdata=8'h3C, req_ready=1 at T+8.
REQ-023 Write of 8'h5A to 16'hA000 -> cart_n_cs low for cycles T+1..T+7, cart_n_wr low for cycles T+3..T+6, cart_data_oe high for cycles T+1..T+7, and cart_data_o=8'h5A.
REQ-024 Window edges -> writes to 16'h9FFF and 16'hC000 give cart_n_cs=1; 16'hBFFF gives cart_n_cs=0.
REQ-025 req_valid held high for 3 requests -> exactly 3 rsp_valid pulses, 8 cycles apart.
REQ-026 n_rst=0 at cycle T+4 of a write -> cart_n_wr=1 and cart_data_oe=0 immediately, no rsp_valid, and the BOOT sequence repeats.
